// File: rtl/regfile_server.sv
// -----------------------------------------------------------------------------
// regfile_server
//   Architectural integer register file with two combinational read ports,
//   one write-back port, write-to-read bypass and a per-register busy
//   scoreboard used by decode/issue to stall on RAW hazards. x0 reads as zero
//   and can never be written or marked busy.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-low reset
//   read0_addr     read port 0 address
//   read0_val      read port 0 data (combinational, bypassed)
//   read1_addr     read port 1 address
//   read1_val      read port 1 data (combinational, bypassed)
//   read0_busy     register at read0_addr has an outstanding producer
//   read1_busy     register at read1_addr has an outstanding producer
//   wr_en          write-back valid
//   wr_addr        write-back destination
//   wr_data        write-back data
//   busy_set       issue claims a destination this cycle
//   busy_set_addr  destination being claimed
//   flush          clear all busy bits (pipeline squash)
//   pending_count  number of busy registers (registered)
// -----------------------------------------------------------------------------
module regfile_server #(
    parameter  int NREGS = 32,
    parameter  int XLEN  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   read0_addr,
    output logic [XLEN-1:0] read0_val,
    input  logic [AW-1:0]   read1_addr,
    output logic [XLEN-1:0] read1_val,
    output logic            read0_busy,
    output logic            read1_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            busy_set,
    input  logic [AW-1:0]   busy_set_addr,
    input  logic            flush,
    output logic [AW:0]     pending_count
);

    logic [XLEN-1:0] regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;
    logic [AW:0]      count_nxt_s;

    // Number of set bits in a busy vector; x0 is never set so the result
    // fits in AW+1 bits without wrapping.
    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] vec);
        logic [AW:0] acc;
        acc = '0;
        for (int k = 0; k < NREGS; k++) begin
            acc = acc + {{AW{1'b0}}, vec[k]};
        end
        return acc;
    endfunction

    // Read port 0: x0 forced to zero, then same-cycle write bypass, then array.
    always_comb begin
        read0_val = '0;
        if (read0_addr == '0) begin
            read0_val = '0;
        end else if (wr_en && (wr_addr == read0_addr)) begin
            read0_val = wr_data;
        end else begin
            read0_val = regs_r[read0_addr];
        end
    end

    // Read port 1: same priority as port 0.
    always_comb begin
        read1_val = '0;
        if (read1_addr == '0) begin
            read1_val = '0;
        end else if (wr_en && (wr_addr == read1_addr)) begin
            read1_val = wr_data;
        end else begin
            read1_val = regs_r[read1_addr];
        end
    end

    // Busy outputs: a completing write un-busies its register in the same
    // cycle, matching the data bypass above.
    always_comb begin
        read0_busy = 1'b0;
        read1_busy = 1'b0;
        if (read0_addr == '0) begin
            read0_busy = 1'b0;
        end else begin
            read0_busy = busy_r[read0_addr] && !(wr_en && (wr_addr == read0_addr));
        end
        if (read1_addr == '0) begin
            read1_busy = 1'b0;
        end else begin
            read1_busy = busy_r[read1_addr] && !(wr_en && (wr_addr == read1_addr));
        end
    end

    // Scoreboard next state: flush beats set, set beats clear (a new producer
    // claiming the register outranks the write-back of the old one).
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < NREGS; i++) begin
            if (flush) begin
                busy_nxt_s[i] = 1'b0;
            end else if (busy_set && (busy_set_addr == AW'(i)) && (i != 0)) begin
                busy_nxt_s[i] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
        busy_nxt_s[0] = 1'b0;
        count_nxt_s   = popcount(busy_nxt_s);
    end

    // Register array write; x0 is never written so it stays at its reset zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_r[wr_addr] <= wr_data;
        end else begin
            regs_r[0] <= '0;
        end
    end

    // Scoreboard and pending count update on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r        <= '0;
            pending_count <= '0;
        end else begin
            busy_r        <= busy_nxt_s;
            pending_count <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_regfile_server.sv
// -----------------------------------------------------------------------------
// tb_regfile_server
//   Directed stimulus for regfile_server. The driver pushes expected output
//   values, tagged with the cycle they belong to, into a queue; a monitor on
//   the falling edge pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_regfile_server;

    localparam int K_R0VAL  = 0;
    localparam int K_R1VAL  = 1;
    localparam int K_R0BUSY = 2;
    localparam int K_R1BUSY = 3;
    localparam int K_COUNT  = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  read0_addr;
    logic [31:0] read0_val;
    logic [4:0]  read1_addr;
    logic [31:0] read1_val;
    logic        read0_busy;
    logic        read1_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy_set;
    logic [4:0]  busy_set_addr;
    logic        flush;
    logic [5:0]  pending_count;

    exp_t exp_q[$];
    int   cyc_cnt;
    int   checks;
    int   errors;

    regfile_server #(.NREGS(32), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .read0_addr    (read0_addr),
        .read0_val     (read0_val),
        .read1_addr    (read1_addr),
        .read1_val     (read1_val),
        .read0_busy    (read0_busy),
        .read1_busy    (read1_busy),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy_set      (busy_set),
        .busy_set_addr (busy_set_addr),
        .flush         (flush),
        .pending_count (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to tag expectations.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare every expectation belonging to the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_R0VAL:  act = read0_val;
                K_R1VAL:  act = read1_val;
                K_R0BUSY: act = {31'd0, read0_busy};
                K_R1BUSY: act = {31'd0, read1_busy};
                default:  act = {26'd0, pending_count};
            endcase
            checks++;
            if (e.cyc != cyc_cnt) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d checked in cycle %0d", e.name, e.cyc, cyc_cnt);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", e.name, act, e.val, cyc_cnt);
            end
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic bs, input logic [4:0] bsa, input logic fl,
                         input logic [4:0] r0, input logic [4:0] r1);
        wr_en = we; wr_addr = wa; wr_data = wd;
        busy_set = bs; busy_set_addr = bsa; flush = fl;
        read0_addr = r0; read1_addr = r1;
    endtask

    task automatic expect_out(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = cyc_cnt; e.kind = kind; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc_cnt = 0;
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        tick();

        // 1: writes and claims during reset must be discarded
        drive(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd6, 1'b0, 5'd5, 5'd6);
        tick(); tick(); tick();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd6);
        expect_out(K_R0VAL,  32'd0, "reset_x5");
        expect_out(K_R1VAL,  32'd0, "reset_x6");
        expect_out(K_R1BUSY, 32'd0, "reset_busy_x6");
        expect_out(K_COUNT,  32'd0, "reset_count");
        tick();

        // 2: bypass then array read
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        expect_out(K_R0VAL, 32'hDEAD_BEEF, "bypass_x5");
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        expect_out(K_R0VAL, 32'hDEAD_BEEF, "array_x5");
        expect_out(K_COUNT, 32'd0, "write_nonbusy_count");
        tick();

        // 3: x0 write and claim are ignored
        drive(1'b1, 5'd0, 32'h0000_1234, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        expect_out(K_R0VAL,  32'd0, "x0_bypass_zero");
        expect_out(K_R0BUSY, 32'd0, "x0_busy_same");
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        expect_out(K_R0VAL,  32'd0, "x0_array_zero");
        expect_out(K_R0BUSY, 32'd0, "x0_busy_next");
        expect_out(K_COUNT,  32'd0, "x0_count");
        tick();

        // 4: claim x7, then write-back releases it
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
        expect_out(K_R1BUSY, 32'd0, "set_x7_same");
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        expect_out(K_R1BUSY, 32'd1, "set_x7_next");
        expect_out(K_COUNT,  32'd1, "set_x7_count");
        tick();
        drive(1'b1, 5'd7, 32'h0000_0055, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        expect_out(K_R1BUSY, 32'd0, "wb_x7_busy");
        expect_out(K_R1VAL,  32'h0000_0055, "wb_x7_val");
        expect_out(K_COUNT,  32'd1, "wb_x7_count_same");
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        expect_out(K_R1BUSY, 32'd0, "wb_x7_busy_next");
        expect_out(K_COUNT,  32'd0, "wb_x7_count_next");
        tick();

        // 5: set and clear of busy x3 in the same cycle -> set wins
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        tick();
        drive(1'b1, 5'd3, 32'h0000_000A, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        expect_out(K_R0BUSY, 32'd0, "setclr_x3_busy_same");
        expect_out(K_R0VAL,  32'h0000_000A, "setclr_x3_bypass");
        expect_out(K_COUNT,  32'd1, "setclr_x3_count_same");
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        expect_out(K_R0BUSY, 32'd1, "setclr_x3_busy_next");
        expect_out(K_R0VAL,  32'h0000_000A, "setclr_x3_array");
        expect_out(K_COUNT,  32'd1, "setclr_x3_count_next");
        tick();
        drive(1'b1, 5'd3, 32'h0000_000B, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
        expect_out(K_COUNT, 32'd1, "reset_x3_count_hold");
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
        expect_out(K_R0BUSY, 32'd0, "release_x3_busy");
        expect_out(K_COUNT,  32'd0, "release_x3_count");
        tick();

        // 6: three busy registers, then flush overriding a new claim
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 1'b0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd31);
        expect_out(K_COUNT,  32'd3, "three_busy_count");
        expect_out(K_R0BUSY, 32'd1, "busy_x1");
        expect_out(K_R1BUSY, 32'd1, "busy_x31");
        tick();
        drive(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd4, 1'b1, 5'd4, 5'd2);
        expect_out(K_R0BUSY, 32'd0, "flush_x4_same");
        expect_out(K_R1BUSY, 32'd1, "flush_x2_same");
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd31);
        expect_out(K_R0BUSY, 32'd0, "flush_x4_next");
        expect_out(K_R1BUSY, 32'd0, "flush_x31_next");
        expect_out(K_COUNT,  32'd0, "flush_count");
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd2);
        expect_out(K_R0VAL,  32'h0000_0099, "flush_write_x9");
        expect_out(K_R1BUSY, 32'd0, "flush_x2_next");
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
